// File: rtl/algo_1r1w_sram_delay_model_if.sv
// ---------------------------------------------------------------------------
// algo_1r1w_sram_delay_model_if
// Bundles the 1r1w physical-memory bank signals between one t1 bank slice of
// the dup/align/stack memory top (master) and the SRAM delay model (slave).
//
// Signals:
//   writeA   write strobe, port A
//   addrA    write row address
//   bwA      per-bit write enable
//   dinA     write data
//   readB    read strobe, port B
//   addrB    read row address
//   doutB    read data, returned SRAM_DELAY cycles after readB
//   vldB     doutB carries a returned read this cycle
//   ready    init sweep complete; requests accepted only while high
//   init_cnt current init sweep row (debug visibility)
// ---------------------------------------------------------------------------
interface algo_1r1w_sram_delay_model_if #(
   parameter int WIDTH   = 128,
   parameter int BITADDR = 8
);
   logic               writeA;
   logic [BITADDR-1:0] addrA;
   logic [WIDTH-1:0]   bwA;
   logic [WIDTH-1:0]   dinA;
   logic               readB;
   logic [BITADDR-1:0] addrB;
   logic [WIDTH-1:0]   doutB;
   logic               vldB;
   logic               ready;
   logic [BITADDR-1:0] init_cnt;

   // Upstream bank logic: issues requests, consumes read data.
   modport master (
      output writeA, addrA, bwA, dinA, readB, addrB,
      input  doutB, vldB, ready, init_cnt
   );

   // Memory model: accepts requests, returns read data.
   modport slave (
      input  writeA, addrA, bwA, dinA, readB, addrB,
      output doutB, vldB, ready, init_cnt
   );
endinterface

// File: rtl/algo_1r1w_sram_delay_model.sv
// ---------------------------------------------------------------------------
// algo_1r1w_sram_delay_model
// Behavioural 1r1w physical memory placed directly below one t1 bank.
// - Bit-masked writes on port A, reads on port B with a fixed SRAM_DELAY
//   (1..8) cycle pipeline, fully pipelined and in order.
// - Same-cycle write/read to one row is read-before-write.
// - After rst, an init sweep writes INITVAL to every row (one row per cycle,
//   NUMADDR cycles); requests are ignored until ready rises.
// - All outputs come straight from registers.
//
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of algo_1r1w_sram_delay_model_if
//        (writeA/addrA/bwA/dinA, readB/addrB in; doutB/vldB/ready/init_cnt out)
// ---------------------------------------------------------------------------
module algo_1r1w_sram_delay_model #(
   parameter int               WIDTH      = 128,
   parameter int               NUMADDR    = 256,
   parameter int               BITADDR    = 8,
   parameter int               SRAM_DELAY = 2,
   parameter logic [WIDTH-1:0] INITVAL    = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   algo_1r1w_sram_delay_model_if.slave   bus
);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam logic [BITADDR-1:0] LAST_ROW    = BITADDR'(NUMADDR - 1);
   localparam logic [BITADDR:0]   NUMADDR_EXT = (BITADDR+1)'(NUMADDR);

   // ------------------------------------------------------------------
   // Control FSM: init sweep, then READY until the next rst.
   // ------------------------------------------------------------------
   state_t             state_q;
   logic               ready_q;
   logic [BITADDR-1:0] init_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               // The counter stops on the last row so it reads NUMADDR-1
               // for the whole READY phase.
               if (init_cnt_q == LAST_ROW) begin
                  state_q <= ST_READY;
                  ready_q <= 1'b1;
               end else begin
                  init_cnt_q <= init_cnt_q + BITADDR'(1);
               end
            end
            ST_READY: begin
               state_q <= ST_READY;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_INIT;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Single write port shared by the init sweep and port A.
   // ------------------------------------------------------------------
   logic               wr_en;
   logic [BITADDR-1:0] wr_addr;
   logic [WIDTH-1:0]   wr_mask;
   logic [WIDTH-1:0]   wr_data;
   logic               wr_in_range;
   logic               rd_in_range;
   logic               rd_fire;

   // Rows beyond NUMADDR exist only when NUMADDR is not a power of two.
   assign wr_in_range = ({1'b0, bus.addrA} < NUMADDR_EXT);
   assign rd_in_range = ({1'b0, bus.addrB} < NUMADDR_EXT);
   assign rd_fire     = !rst && (state_q == ST_READY) && bus.readB;

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = init_cnt_q;
      wr_mask = '1;
      wr_data = INITVAL;
      if (!rst) begin
         if (state_q == ST_INIT) begin
            wr_en = 1'b1;
         end else if (bus.writeA && wr_in_range) begin
            wr_en   = 1'b1;
            wr_addr = bus.addrA;
            wr_mask = bus.bwA;
            wr_data = bus.dinA;
         end
      end
   end

   // ------------------------------------------------------------------
   // Array with per-bit write enables and a registered read port.
   // Both ports use non-blocking updates on the same edge, so a read of
   // the row being written returns the old contents.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] mem [NUMADDR];
   logic             rd_vld_q;
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < WIDTH; b++) begin
            if (wr_mask[b]) begin
               mem[wr_addr][b] <= wr_data[b];
            end
         end
      end
      if (rst) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_vld_q <= rd_fire;
         // Data registers only load on a valid read, so the last stage
         // holds the most recently returned word between reads.
         if (rd_fire) begin
            rd_data_q <= rd_in_range ? mem[bus.addrB] : '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read delay line: stage 0 is the array output register, stages
   // 1..SRAM_DELAY-1 add the remaining latency.
   // ------------------------------------------------------------------
   logic             stage_vld  [SRAM_DELAY];
   logic [WIDTH-1:0] stage_data [SRAM_DELAY];

   assign stage_vld[0]  = rd_vld_q;
   assign stage_data[0] = rd_data_q;

   genvar gi;
   generate
      for (gi = 1; gi < SRAM_DELAY; gi++) begin : g_stage
         logic             vld_q;
         logic [WIDTH-1:0] data_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q  <= 1'b0;
               data_q <= '0;
            end else begin
               vld_q <= stage_vld[gi-1];
               if (stage_vld[gi-1]) begin
                  data_q <= stage_data[gi-1];
               end
            end
         end

         assign stage_vld[gi]  = vld_q;
         assign stage_data[gi] = data_q;
      end
   endgenerate

   assign bus.doutB    = stage_data[SRAM_DELAY-1];
   assign bus.vldB     = stage_vld[SRAM_DELAY-1];
   assign bus.ready    = ready_q;
   assign bus.init_cnt = init_cnt_q;

endmodule

// File: tb/tb_algo_1r1w_sram_delay_model.sv
// ---------------------------------------------------------------------------
// tb_algo_1r1w_sram_delay_model
// Table-driven vectors, hand-written reset/init sequences and random traffic,
// all checked against a queue-based reference model of the memory.
// ---------------------------------------------------------------------------
module tb_algo_1r1w_sram_delay_model;
   localparam int               W     = 128;
   localparam int               NA    = 256;
   localparam int               BA    = 8;
   localparam int               DELAY = 2;
   localparam logic [W-1:0]     IV    = '0;

   logic clk;
   logic rst;

   algo_1r1w_sram_delay_model_if #(.WIDTH(W), .BITADDR(BA)) bus ();

   algo_1r1w_sram_delay_model #(
      .WIDTH(W), .NUMADDR(NA), .BITADDR(BA), .SRAM_DELAY(DELAY), .INITVAL(IV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [W-1:0] data;
      int           due;
   } pend_t;

   logic [W-1:0] m_mem [NA];
   pend_t        pend [$];
   int           edge_n   = 0;
   bit           m_rdy    = 1'b0;
   int           m_cnt    = 0;
   bit           m_vld    = 1'b0;
   logic [W-1:0] m_dout   = '0;
   bit           checking = 1'b0;

   task automatic model_edge(input logic r, input logic wa, input logic [BA-1:0] aa,
                             input logic [W-1:0] bw, input logic [W-1:0] din,
                             input logic rb, input logic [BA-1:0] ab);
      edge_n++;
      m_vld = 1'b0;
      if (r) begin
         m_rdy    = 1'b0;
         m_cnt    = 0;
         m_dout   = '0;
         checking = 1'b1;
         pend.delete();
      end else begin
         if (!m_rdy) begin
            m_mem[m_cnt] = IV;
            if (m_cnt == NA - 1) m_rdy = 1'b1;
            else m_cnt++;
         end else begin
            // A read captures the row as it stood before this edge's write.
            if (rb) pend.push_back('{data: (int'(ab) < NA) ? m_mem[ab] : '0,
                                     due: edge_n + DELAY - 1});
            if (wa && int'(aa) < NA) m_mem[aa] = (m_mem[aa] & ~bw) | (din & bw);
         end
         if (pend.size() > 0 && pend[0].due == edge_n) begin
            m_vld  = 1'b1;
            m_dout = pend[0].data;
            void'(pend.pop_front());
         end
      end
   endtask

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, update the model, check outputs.
   task automatic tick(input logic r, input logic wa, input logic [BA-1:0] aa,
                       input logic [W-1:0] bw, input logic [W-1:0] din,
                       input logic rb, input logic [BA-1:0] ab);
      rst        = r;
      bus.writeA = wa;
      bus.addrA  = aa;
      bus.bwA    = bw;
      bus.dinA   = din;
      bus.readB  = rb;
      bus.addrB  = ab;
      @(posedge clk);
      model_edge(r, wa, aa, bw, din, rb, ab);
      #1;
      if (checking) begin
         chk($sformatf("vldB@%0d", edge_n), W'(bus.vldB), W'(m_vld));
         chk($sformatf("doutB@%0d", edge_n), bus.doutB, m_dout);
         chk($sformatf("ready@%0d", edge_n), W'(bus.ready), W'(m_rdy));
         chk($sformatf("init_cnt@%0d", edge_n), W'(bus.init_cnt), W'(m_cnt));
      end
   endtask

   task automatic idle(input logic r);
      tick(r, 1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          wa;
      logic [BA-1:0] aa;
      logic [W-1:0]  bw;
      logic [W-1:0]  din;
      logic          rb;
      logic [BA-1:0] ab;
      logic          exp_vld;
      logic [W-1:0]  exp_dout;
   } vec_t;

   function automatic vec_t mk(input logic wa, input logic [BA-1:0] aa, input logic [W-1:0] bw,
                               input logic [W-1:0] din, input logic rb, input logic [BA-1:0] ab,
                               input logic ev, input logic [W-1:0] ed);
      vec_t v;
      v.wa = wa; v.aa = aa; v.bw = bw; v.din = din;
      v.rb = rb; v.ab = ab; v.exp_vld = ev; v.exp_dout = ed;
      return v;
   endfunction

   vec_t vecs [16];

   initial begin
      logic [W-1:0] ones;
      logic [W-1:0] a5;
      logic [W-1:0] masked;
      int           n;
      int           vld_pulses;

      ones   = '1;
      a5     = {16{8'hA5}};
      masked = {{(W-16){1'b1}}, 16'h0000};

      // Outputs listed are those seen after the row's clock edge (DELAY=2).
      vecs[0]  = mk(0, 0,   '0,       '0,     1, 0,   0, '0);       // read row 0
      vecs[1]  = mk(0, 0,   '0,       '0,     1, 128, 1, '0);       // read row 128
      vecs[2]  = mk(0, 0,   '0,       '0,     1, 255, 1, '0);       // read row 255
      vecs[3]  = mk(1, 5,   ones,     a5,     0, 0,   1, '0);       // write row 5
      vecs[4]  = mk(0, 0,   '0,       '0,     0, 0,   0, '0);
      vecs[5]  = mk(0, 0,   '0,       '0,     1, 5,   0, '0);       // read 5
      vecs[6]  = mk(0, 0,   '0,       '0,     1, 6,   1, a5);       // read 6
      vecs[7]  = mk(0, 0,   '0,       '0,     1, 5,   1, '0);       // read 5
      vecs[8]  = mk(1, 9,   ones,     ones,   0, 0,   1, a5);       // row 9 = ones
      vecs[9]  = mk(1, 9,   W'(16'hFFFF), '0, 0, 0,   0, a5);       // clear low 16
      vecs[10] = mk(0, 0,   '0,       '0,     1, 9,   0, a5);       // read 9
      vecs[11] = mk(1, 3,   ones,     W'(8'h11), 0, 0, 1, masked);  // row 3 = 0x11
      vecs[12] = mk(1, 3,   ones,     W'(8'h22), 1, 3, 0, masked);  // collide
      vecs[13] = mk(0, 0,   '0,       '0,     1, 3,   1, W'(8'h11));
      vecs[14] = mk(0, 0,   '0,       '0,     0, 0,   1, W'(8'h22));
      vecs[15] = mk(0, 0,   '0,       '0,     0, 0,   0, W'(8'h22));

      // ---------- reset sweep ----------
      idle(1'b1);
      idle(1'b1);
      chk("reset_vldB", W'(bus.vldB), '0);
      chk("reset_doutB", bus.doutB, '0);
      chk("reset_ready", W'(bus.ready), '0);
      for (int i = 0; i < NA - 1; i++) idle(1'b0);
      chk("sweep_ready_early", W'(bus.ready), '0);
      idle(1'b0);
      chk("sweep_ready_256", W'(bus.ready), W'(1));
      chk("sweep_init_cnt", W'(bus.init_cnt), W'(NA - 1));
      $display("sweep: ready=%0d init_cnt=%0d after %0d cycles", bus.ready, bus.init_cnt, NA);

      // ---------- table vectors ----------
      for (int i = 0; i < 16; i++) begin
         tick(1'b0, vecs[i].wa, vecs[i].aa, vecs[i].bw, vecs[i].din, vecs[i].rb, vecs[i].ab);
         $display("vec %0d: wa=%0d aa=%0d rb=%0d ab=%0d -> vldB=%0d doutB=%h",
                  i, vecs[i].wa, vecs[i].aa, vecs[i].rb, vecs[i].ab, bus.vldB, bus.doutB);
         chk($sformatf("vec%0d_vld", i), W'(bus.vldB), W'(vecs[i].exp_vld));
         chk($sformatf("vec%0d_dout", i), bus.doutB, vecs[i].exp_dout);
      end

      // Row 7 holds a non-INITVAL value so a leaked INIT write would show.
      tick(1'b0, 1'b1, 8'd7, ones, ones, 1'b0, '0);

      // ---------- reset mid-sweep, requests during INIT ----------
      idle(1'b1);
      n = 0;
      while (bus.init_cnt != 8'd100 && n < 300) begin
         tick(1'b0, 1'b1, 8'd7, ones, W'(8'hFF), (n % 3) == 0, BA'(n));
         n++;
      end
      chk("midsweep_reach100", W'(bus.init_cnt), W'(100));
      tick(1'b1, 1'b1, 8'd7, ones, W'(8'hFF), 1'b1, 8'd7);
      chk("midsweep_restart", W'(bus.init_cnt), '0);
      n = 0;
      vld_pulses = 0;
      while (!bus.ready && n < 400) begin
         tick(1'b0, 1'b1, 8'd7, ones, W'(8'hFF), (n % 2) == 0, 8'd7);
         if (bus.vldB) vld_pulses++;
         n++;
      end
      chk("ready_latency", W'(n), W'(NA));
      chk("init_vld_pulses", W'(vld_pulses), '0);
      $display("midsweep: ready after %0d cycles, vld pulses in INIT=%0d", n, vld_pulses);
      tick(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'd7);
      idle(1'b0);
      chk("row7_vld", W'(bus.vldB), W'(1));
      chk("row7_initval", bus.doutB, IV);
      $display("row7 after init: vldB=%0d doutB=%h", bus.vldB, bus.doutB);

      // ---------- random traffic on a small row set ----------
      for (int i = 0; i < 800; i++) begin
         logic [W-1:0] bw;
         logic [W-1:0] din;
         int           sel;
         sel = $urandom_range(0, 2);
         bw  = (sel == 0) ? ones : (sel == 1) ? '0 : {$urandom, $urandom, $urandom, $urandom};
         din = {$urandom, $urandom, $urandom, $urandom};
         tick(1'b0, 1'($urandom_range(0, 1)), BA'($urandom_range(0, 15)), bw, din,
              1'($urandom_range(0, 1)), BA'($urandom_range(0, 15)));
      end
      repeat (DELAY + 1) idle(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
